// File: rtl/stitch_pipe_ctrl.sv
// Valid/ready controller driving load enables for the p1..pN banks of a stitched pipeline.
// Latency STAGES cycles; out_ready low stalls the banks. STITCH_PIPE_COLLAPSE_EN lets upstream bubbles collapse, otherwise all banks stall together.
module stitch_pipe_ctrl #(
    parameter int STAGES = 2,
    parameter int OCC_W  = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              flush,
    output logic [STAGES-1:0] stage_en,
    output logic [STAGES-1:0] stage_valid,
    output logic [OCC_W-1:0]  occupancy,
    output logic              busy
);

    logic [STAGES-1:0] valid_q, valid_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [STAGES:0]   v;
    logic [STAGES:1]   adv;
    logic              accept, drain;
`ifdef STITCH_PIPE_COLLAPSE_EN
    logic              adv_up;
`else
    logic              stall;
`endif

    always_comb begin
        v   = {valid_q, in_valid};
        adv = '0;
`ifdef STITCH_PIPE_COLLAPSE_EN
        // Ripple from the output back: a bank may move if it is empty or its successor moves.
        adv_up = out_ready;
        for (int k = STAGES; k >= 1; k--) begin
            adv[k] = !v[k] || adv_up;
            adv_up = adv[k];
        end
`else
        stall = v[STAGES] && !out_ready;
        for (int k = 1; k <= STAGES; k++) begin
            adv[k] = !stall;
        end
`endif
    end

    always_comb begin
        stage_en = '0;
        valid_d  = '0;
        for (int k = 1; k <= STAGES; k++) begin
            stage_en[k-1] = v[k-1] && adv[k] && !flush && rst_n;
            valid_d[k-1]  = !flush && (adv[k] ? v[k-1] : valid_q[k-1]);
        end
    end

    assign in_ready = adv[1] && !flush && rst_n;
    assign accept   = in_valid && in_ready;
    assign drain    = valid_q[STAGES-1] && out_ready;

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q + OCC_W'(accept) - OCC_W'(drain);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
        end
    end

    assign stage_valid = valid_q;
    assign out_valid   = valid_q[STAGES-1];
    assign occupancy   = occ_q;
    assign busy        = |occ_q;

endmodule

// File: tb/tb_stitch_pipe_ctrl.sv
// Directed bench for stitch_pipe_ctrl: a STAGES=2 instance and a STAGES=3 instance with a token-tracking shadow pipeline.
module tb_stitch_pipe_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       r2_n, iv2, ir2, ov2, or2, fl2, busy2;
    logic [1:0] en2, sv2, occ2;
    logic       r3_n, iv3, ir3, ov3, or3, fl3, busy3;
    logic [2:0] en3, sv3;
    logic [1:0] occ3;

    int checks = 0;
    int errors = 0;

    logic [7:0] din3;
    logic [7:0] sd [1:3];

    int en_exp  [8] = '{1, 3, 3, 3, 3, 2, 0, 0};
    int occ_exp [8] = '{0, 1, 2, 2, 2, 2, 1, 0};

    stitch_pipe_ctrl #(.STAGES(2)) dut2 (
        .clk(clk), .rst_n(r2_n), .in_valid(iv2), .in_ready(ir2), .out_valid(ov2),
        .out_ready(or2), .flush(fl2), .stage_en(en2), .stage_valid(sv2),
        .occupancy(occ2), .busy(busy2)
    );

    stitch_pipe_ctrl #(.STAGES(3)) dut3 (
        .clk(clk), .rst_n(r3_n), .in_valid(iv3), .in_ready(ir3), .out_valid(ov3),
        .out_ready(or3), .flush(fl3), .stage_en(en3), .stage_valid(sv3),
        .occupancy(occ3), .busy(busy3)
    );

    // Data banks of a stitched pipeline, loaded only by the controller's enables.
    always_ff @(posedge clk) begin
        if (en3[0]) sd[1] <= din3;
        if (en3[1]) sd[2] <= sd[1];
        if (en3[2]) sd[3] <= sd[2];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        r2_n = 0; iv2 = 1; or2 = 0; fl2 = 0;
        r3_n = 0; iv3 = 0; or3 = 0; fl3 = 0; din3 = 8'h00;

        // Reset
        mid();
        chk("rst_in_ready_low", ir2, 0);
        chk("rst_stage_en_low", en2, 0);
        nxt();
        mid();
        chk("rst_stage_valid2", sv2, 0);
        chk("rst_occ2", occ2, 0);
        chk("rst_out_valid2", ov2, 0);
        chk("rst_busy2", busy2, 0);
        chk("rst_stage_valid3", sv3, 0);
        chk("rst_busy3", busy3, 0);
        nxt();
        r2_n = 1; r3_n = 1; or2 = 1;

        // Streaming, STAGES=2
        for (int c = 0; c < 8; c++) begin
            iv2 = (c <= 4);
            mid();
            chk($sformatf("stream_out_valid_c%0d", c), ov2, (c >= 2 && c <= 6) ? 1 : 0);
            chk($sformatf("stream_stage_en_c%0d", c), en2, en_exp[c]);
            chk($sformatf("stream_occ_c%0d", c), occ2, occ_exp[c]);
            if (c == 3) chk("stream_accept_drain_in_ready", ir2, 1);
            if (c == 0) chk("empty_in_ready", ir2, 1);
            nxt();
        end
        chk("stream_busy_end", busy2, 0);

        // Fill, full stall, pass-through, then flush
        or2 = 0; iv2 = 1;
        mid(); chk("fill_in_ready_0", ir2, 1); nxt();
        mid(); chk("fill_in_ready_1", ir2, 1); chk("fill_en_1", en2, 3); nxt();
        mid();
        chk("full_stage_valid", sv2, 3);
        chk("full_occ", occ2, 2);
        chk("full_in_ready", ir2, 0);
        chk("full_stage_en", en2, 0);
        or2 = 1;
        #1;
        chk("full_passthru_in_ready", ir2, 1);
        chk("full_passthru_en", en2, 3);
        nxt();
        fl2 = 1; iv2 = 1; or2 = 1;
        mid();
        chk("accdrn_occ", occ2, 2);
        chk("flush_in_ready", ir2, 0);
        chk("flush_stage_en", en2, 0);
        chk("flush_out_valid_seen", ov2, 1);
        nxt();
        fl2 = 0; iv2 = 0;
        mid();
        chk("post_flush_stage_valid", sv2, 0);
        chk("post_flush_occ", occ2, 0);
        chk("post_flush_out_valid", ov2, 0);
        chk("post_flush_busy", busy2, 0);
        nxt();

        // Reset mid-operation
        or2 = 0; iv2 = 1;
        nxt(); nxt();
        mid(); chk("pre_reset_occ", occ2, 2); nxt();
        r2_n = 0;
        mid();
        chk("midrst_in_ready", ir2, 0);
        chk("midrst_stage_en", en2, 0);
        nxt();
        r2_n = 1; iv2 = 1;
        mid();
        chk("after_rst_stage_valid", sv2, 0);
        chk("after_rst_occ", occ2, 0);
        chk("after_rst_out_valid", ov2, 0);
        chk("after_rst_busy", busy2, 0);
        chk("after_rst_in_ready", ir2, 1);
        chk("after_rst_first_en", en2, 1);
        nxt();
        iv2 = 0;
        mid();
        chk("after_rst_no_stale_ov", ov2, 0);
        chk("after_rst_stage_valid_1", sv2, 1);
        chk("after_rst_occ_1", occ2, 1);
        nxt();

        // Backpressure, STAGES=3
        iv3 = 1; or3 = 1; din3 = 8'hA1;
        mid(); chk("bp_in_ready_c0", ir3, 1); nxt();
        iv3 = 0;
        nxt(); nxt();
        or3 = 0; iv3 = 1; din3 = 8'hB2;
        mid();
        chk("bp_c3_stage_valid", sv3, 3'b100);
        chk("bp_c3_latency_out_valid", ov3, 1);
        chk("bp_c3_occ", occ3, 1);
`ifdef STITCH_PIPE_COLLAPSE_EN
        chk("bp_c3_in_ready", ir3, 1);
        chk("bp_c3_en", en3, 3'b001);
`else
        chk("bp_c3_in_ready", ir3, 0);
        chk("bp_c3_en", en3, 3'b000);
`endif
        nxt();
        din3 = 8'hC3;
        mid();
`ifdef STITCH_PIPE_COLLAPSE_EN
        chk("bp_c4_stage_valid", sv3, 3'b101);
        chk("bp_c4_occ", occ3, 2);
        chk("bp_c4_in_ready", ir3, 1);
        chk("bp_c4_en", en3, 3'b011);
`else
        chk("bp_c4_stage_valid", sv3, 3'b100);
        chk("bp_c4_occ", occ3, 1);
        chk("bp_c4_in_ready", ir3, 0);
        chk("bp_c4_en", en3, 3'b000);
`endif
        nxt();
        din3 = 8'hEE;
        mid();
`ifdef STITCH_PIPE_COLLAPSE_EN
        chk("bp_c5_stage_valid", sv3, 3'b111);
        chk("bp_c5_occ", occ3, 3);
`else
        chk("bp_c5_stage_valid", sv3, 3'b100);
        chk("bp_c5_occ", occ3, 1);
`endif
        chk("bp_c5_in_ready", ir3, 0);
        chk("bp_c5_en", en3, 0);
        nxt();
        mid(); chk("bp_c6_in_ready", ir3, 0); nxt();
        or3 = 1; iv3 = 0;
        mid();
        chk("bp_c7_out_valid", ov3, 1);
        chk("bp_c7_token", sd[3], 8'hA1);
`ifdef STITCH_PIPE_COLLAPSE_EN
        chk("bp_c7_en", en3, 3'b110);
        nxt();
        mid();
        chk("bp_c8_out_valid", ov3, 1);
        chk("bp_c8_token", sd[3], 8'hB2);
        chk("bp_c8_occ", occ3, 2);
        chk("bp_c8_stage_valid", sv3, 3'b110);
        nxt();
        mid();
        chk("bp_c9_out_valid", ov3, 1);
        chk("bp_c9_token", sd[3], 8'hC3);
        nxt();
        mid();
        chk("bp_c10_out_valid", ov3, 0);
        chk("bp_c10_occ", occ3, 0);
`else
        chk("bp_c7_en", en3, 3'b000);
        nxt();
        mid();
        chk("bp_c8_out_valid", ov3, 0);
        chk("bp_c8_occ", occ3, 0);
        chk("bp_c8_stage_valid", sv3, 0);
`endif
        nxt();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stitch_pipe_ctrl.md
# stitch_pipe_ctrl

Valid/ready flow controller for a stitched, multi-stage combinational pipeline. It generates the load enables for the `p1`…`pN` register banks between the stage instances, and tracks a valid bit per bank. It also exposes a valid/ready handshake at the pipeline input and output. The block carries no data: it sits beside the stitched top and drives the enable of each bank's `always_ff`, so a stitched pipeline can tolerate backpressure and flush.

## Interface
- `STAGES`, default 2: number of register banks. Bank k (1..STAGES) captures the output of stage k-1. Bank STAGES is the output register. Minimum value is 1.
- `OCC_W`, default `$clog2(STAGES+1)`: width of the occupancy counter.

- `clk` in 1: the single clock. All state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: the upstream presents a new transaction to stage 0.
- `in_ready` out 1: the controller accepts it this cycle. Combinational.
- `out_valid` out 1: bank STAGES holds a result. Registered.
- `out_ready` in 1: the downstream consumes the result this cycle.
- `flush` in 1: discard all in-flight transactions.
- `stage_en` out STAGES: bit k-1 is the load enable for bank k. Combinational.
- `stage_valid` out STAGES: bit k-1 is the valid bit of bank k. Registered.
- `occupancy` out OCC_W: number of valid banks. Registered.
- `busy` out 1: high when `occupancy` is non-zero.

## Operation
- **Notation**
  - v[0] = `in_valid`; v[k] = `stage_valid[k-1]`.
  - adv[STAGES+1] = `out_ready`.
  - Accept = `in_valid && in_ready`.
  - Drain = `out_valid && out_ready`.
- **Advance rule (mode-dependent, see Configuration)**
  - Collapse: adv[k] = !v[k] || adv[k+1].
  - Global stall: adv[k] = !(v[STAGES] && !out_ready) for all k.
- **Outputs**
  - en[k] = v[k-1] && adv[k] && !flush.
  - `in_ready` = adv[1] && !flush.
  - `out_valid` = v[STAGES].
- **Next state of v[k]**
  - `flush` high: 0.
  - Otherwise, if adv[k]: v[k-1].
  - Otherwise: v[k] (hold).
- **Occupancy update**
  - Flush: 0.
  - Otherwise: `occupancy` + Accept − Drain. Simultaneous Accept and Drain leaves it unchanged.
  - It never exceeds STAGES; it equals popcount(`stage_valid`) at all times.
- **Flush**
  - Takes priority over all other inputs.
  - `in_valid` during a flush cycle is not accepted.
  - If `out_valid && out_ready` in the flush cycle, that result counts as consumed (the downstream sees the handshake). It is still cleared.
- **Reset**
  - While `rst_n` is low: `in_ready`=0 and `stage_en`=0.
  - At the edge: `stage_valid`=0, `out_valid`=0, `occupancy`=0, `busy`=0.
  - Reset asserted mid-stream discards every in-flight transaction.
- **Ordering**: strict FIFO order; there is no reordering or duplication.

## Timing
- **Latency**: a transaction accepted in cycle t has `out_valid` in cycle t+STAGES, absent stalls.
- **Throughput**: one transaction per cycle while `out_ready` is high.
- **Control paths**
  - `in_ready` and `stage_en` are combinational from `out_ready`, `flush` and state. The worst path is the adv chain, depth STAGES.
  - There is no combinational path from `in_valid` to `in_ready`.
- **Full**: with all banks valid and `out_ready`=0, `in_ready`=0 and `stage_en`=0.
- **Full with `out_ready`=1**: `in_ready`=1 in both modes (pass-through).
- **Empty**: `in_ready`=1, `out_valid`=0.
- **Reset release**: the first accept is possible in the first cycle with `rst_n`=1.

## Configuration
- `STITCH_PIPE_COLLAPSE_EN` defined:
  - Bubble-collapsing advance rule.
  - A stalled output lets upstream banks fill their empty slots; `in_ready` stays high until all banks are valid.
- `STITCH_PIPE_COLLAPSE_EN` not defined:
  - Global-stall rule.
  - Any `out_valid && !out_ready` freezes every bank and drops `in_ready`, even with bubbles present.
  - Cheaper; the adv chain is replaced by a single stall term.

## Test plan
- **Streaming**: STAGES=2, `in_valid`=1 for cycles 0–4, `out_ready`=1 → `out_valid` high in cycles 2–6. `stage_en`=2'b11 in cycles 1–4. `occupancy` goes 0,1,2,2,2,2,1 and then 0 in cycle 7.
- **Backpressure, collapse on**: STAGES=3, one transaction, then `out_ready`=0 from cycle 3 with `in_valid`=1 → two more accepts. `in_ready`=0 once `occupancy`=3. Raising `out_ready` yields 3 results in order, on consecutive cycles.
- **Backpressure, collapse off**: same stimulus → `in_ready`=0 from cycle 3 while `occupancy`=1. No banks load until `out_ready` returns.
- **Flush**: STAGES=2 full, with `flush` pulsed for 1 cycle together with `in_valid`=1 → the next cycle has `stage_valid`=0, `occupancy`=0 and `out_valid`=0. The flush-cycle input is not accepted.
- **Simultaneous accept and drain**: STAGES=2 full, `out_ready`=1, `in_valid`=1 → `occupancy` stays 2 and `in_ready`=1.
- **Reset mid-operation**: STAGES=2 with 2 transactions in flight, `rst_n`=0 for 1 cycle → `in_ready`=0 during reset. Afterwards all outputs are 0 except `in_ready`=1, and no stale `out_valid` appears.
